// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches aligned 16-byte lines into a 32-byte circular
// byte queue and presents a 16-byte decode window starting at de_eip.

module fq_lane #(
  parameter int QBYTES = 32,
  parameter int LANE   = 0
) (
  input  logic [QBYTES-1:0][7:0] q,
  input  logic [4:0]             head,
  input  logic [4:0]             avail,
  output logic [7:0]             b
);
  logic [4:0] idx;
  assign idx = head + 5'(LANE);
  // Bytes past the valid count are forced to zero so an empty queue shows a clean window.
  assign b   = (5'(LANE) < avail) ? q[idx] : 8'h00;
endmodule

module fetch_queue #(
  parameter logic [31:0] RESET_EIP = 32'h0000FFF0,
  parameter int          QBYTES    = 32
) (
  input  logic         clk,
  input  logic         r,
  input  logic         redirect,
  input  logic [31:0]  redirect_eip,
  output logic         ic_req,
  output logic [31:0]  ic_addr,
  input  logic         ic_rdy,
  input  logic [127:0] ic_data,
  output logic [127:0] de_bytes,
  output logic [4:0]   de_avail,
  output logic [31:0]  de_eip,
  input  logic         de_consume,
  input  logic [4:0]   de_len
);
  localparam int NUM_LANES = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]                    state;
  logic [4:0]                    head, tail;
  logic [5:0]                    count, count_nxt;
  logic [31:0]                   fetch_eip;
  logic [QBYTES-1:0][7:0]        q;
  logic [NUM_LANES-1:0][7:0]     win;
  logic [3:0]                    off;
  logic [4:0]                    n;
  logic                          fill, cons;

  assign de_avail = (count > 6'd16) ? 5'd16 : count[4:0];
  assign off      = fetch_eip[3:0];
  assign n        = 5'd16 - {1'b0, off};
  assign fill     = (state == S_REQ) && ic_rdy && !redirect;
  assign cons     = de_consume && (de_len != 5'd0) && (de_len <= de_avail) && !redirect;

  always_comb begin
    count_nxt = count;
    if (cons) count_nxt = count_nxt - {1'b0, de_len};
    if (fill) count_nxt = count_nxt + {1'b0, n};
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    fq_lane #(.QBYTES(QBYTES), .LANE(i)) u_lane (
      .q     (q),
      .head  (head),
      .avail (de_avail),
      .b     (win[i])
    );
  end
  assign de_bytes = win;

  // Line bytes below the fetch offset belong to addresses before fetch_eip and are skipped.
  always_ff @(posedge clk) begin
    if (fill) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (4'(k) >= off)
          q[tail + 5'(k) - {1'b0, off}] <= ic_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state     <= S_IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      fetch_eip <= RESET_EIP;
      de_eip    <= RESET_EIP;
      ic_req    <= 1'b0;
      ic_addr   <= '0;
    end else if (redirect) begin
      head      <= tail;
      count     <= '0;
      fetch_eip <= redirect_eip;
      de_eip    <= redirect_eip;
      // An outstanding request must still complete on the bus; its data is thrown away.
      case (state)
        S_REQ: begin
          if (ic_rdy) begin
            state  <= S_IDLE;
            ic_req <= 1'b0;
          end else begin
            state  <= S_DROP;
          end
        end
        S_DROP: begin
          if (ic_rdy) begin
            state  <= S_IDLE;
            ic_req <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end else begin
      count <= count_nxt;
      if (cons) begin
        head   <= head + de_len;
        de_eip <= de_eip + 32'(de_len);
      end
      case (state)
        S_IDLE: begin
          if (count <= 6'd16) begin
            state   <= S_REQ;
            ic_req  <= 1'b1;
            ic_addr <= {fetch_eip[31:4], 4'h0};
          end
        end
        S_REQ: begin
          if (ic_rdy) begin
            state     <= S_IDLE;
            ic_req    <= 1'b0;
            tail      <= tail + n;
            fetch_eip <= ic_addr + 32'd16;
          end
        end
        S_DROP: begin
          if (ic_rdy) begin
            state  <= S_IDLE;
            ic_req <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          ic_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch/prefetch stage directly upstream of decode.
- Fetches 16-byte aligned lines from instruction memory and holds them in a 32-byte circular byte queue.
- Presents a 16-byte window starting at the current decode EIP; decode retires 1–16 bytes per cycle.
- Flushes and refetches when a control transfer writes EIP (the v_eipw / mr_eip path out of mem-read).

Parameters:
- RESET_EIP, 32'h0000FFF0, fetch/decode EIP after reset.
- QBYTES, 32, queue capacity in bytes. Fixed at 2x line size; other values are unsupported.

Ports:
- clk  in  1  clock; all state updates on posedge.
- r  in  1  reset, synchronous, active-high.
- redirect  in  1  EIP write from a taken control transfer (v_eipw).
- redirect_eip  in  32  new EIP (mr_eip).
- ic_req  out  1  fetch request; held high until ic_rdy.
- ic_addr  out  32  line address, bits [3:0]=0; stable while ic_req=1.
- ic_rdy  in  1  single-cycle pulse: ic_data valid, request complete.
- ic_data  in  128  line data; byte k at [8k+7:8k].
- de_bytes  out  128  window; [7:0] = byte at de_eip.
- de_avail  out  5  valid window bytes, 0..16.
- de_eip  out  32  address of de_bytes[7:0].
- de_consume  in  1  decode retires bytes this cycle (gated by ld_de upstream).
- de_len  in  5  bytes retired, 1..16.

Behaviour:
- Reset (r=1 at posedge):
  - state=IDLE, head=tail=count=0.
  - fetch_eip=de_eip=RESET_EIP.
  - ic_req=0, ic_addr=0, de_avail=0, de_bytes=0.
- All outputs are registered or derived only from registers.
- de_avail = min(count,16). Bytes at positions >= de_avail are don't-care.
- ic_addr = {fetch_eip[31:4],4'h0}.
- State machine:
  - IDLE: if count<=16 and no redirect, go to REQ and ic_req=1 next cycle. First request after reset release appears 1 cycle later.
  - REQ: wait for ic_rdy. On ic_rdy:
    - n = 16 - fetch_eip[3:0].
    - Bytes fetch_eip[3:0]..15 of ic_data are appended at tail; count += n.
    - fetch_eip = ic_addr + 16.
    - Next state is IDLE. A new request may be issued the following cycle.
  - DROP: entered on redirect while in REQ without ic_rdy. ic_req and ic_addr are held unchanged until ic_rdy; the returned data is discarded; then go to IDLE.
- Redirect, any state:
  - Queue flushed: count=0, head=tail.
  - de_eip = fetch_eip = redirect_eip, visible the next cycle.
  - Redirect wins over a same-cycle de_consume and over same-cycle ic_rdy data; that data is discarded and the next state is IDLE.
- Consume:
  - If de_consume and 1 <= de_len <= de_avail: head += de_len (mod 32), de_eip += de_len (mod 2^32), count -= de_len.
  - If de_len=0 or de_len > de_avail: the consume is ignored and state is unchanged. The bench checks no corruption.
- Simultaneous consume and fill: count_next = count - de_len + n. This never exceeds 32 because a request is only issued at count <= 16.
- Wrap-around:
  - Head and tail indices wrap mod 32; the window read wraps across the array end.
  - EIP arithmetic wraps mod 2^32.
- Reset during REQ or DROP: immediate return to IDLE with ic_req=0. A late ic_rdy arriving while in IDLE is ignored.
- Queue full (count > 16): no request is issued; consume proceeds normally.

Test Plan:
- Reset then first fill: release r; cycle 1 ic_req=1, ic_addr=0x0000FFF0; reply with ic_data bytes 0x00..0x0F → de_avail=16, de_eip=0xFFF0, de_bytes[7:0]=0x00. Next request ic_addr=0x00010000.
- Consume plus fill in the same cycle: count=16, de_len=3, ic_rdy with bytes 0x10..0x1F → de_eip=0xFFF3, count=29, de_bytes[7:0]=0x03, de_bytes[127:120]=0x12.
- Unaligned redirect: redirect_eip=0x00001005 → ic_addr=0x1000; reply with bytes 0x40..0x4F → de_avail=11, de_bytes[7:0]=0x45, de_eip=0x1005.
- Redirect during outstanding request: ic_req pending at 0x2000, redirect to 0x3000 → ic_addr stays 0x2000 until ic_rdy; that data is dropped and de_avail stays 0; the next request is at 0x3000.
- Full queue and over-consume: count=32 → ic_req stays 0 for 10 cycles. de_len=17 or de_len=0 → de_eip and de_avail unchanged.
- Head wrap: retire 5 bytes then 14 bytes across index 31→0 → window bytes contiguous and equal to fetched memory image; de_eip advanced by 19.
